jtag_reg_ctrl: RTL

Command controller behind JTAG user chain 1. It owns the chain's 32-bit shift register and decodes each updated word as a command: NOP, WRITE, READ or STATUS. WRITE and READ are issued to a register bank (LED register and future peripherals) over a req/ack handshake in the JTCK domain. Read data and status are returned to the host on the next capture.

---
 rtl/jtag_reg_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/jtag_reg_ctrl.sv
// jtag_reg_ctrl
//   Command controller behind JTAG user chain 1. Owns the chain's shift
//   register and decodes each updated word {op, addr, data} as NOP, WRITE,
//   READ or STATUS. WRITE/READ are issued on a req/ack register-bank bus in
//   the JTCK domain. Read data and status are returned on the next capture.
//
// Ports
//   JTCK, JRSTN          clock (rising edge), async active-low reset
//   JTDI, JTD1           serial in / serial out (sr[0])
//   JSHIFT, JUPDATE,     shift-DR qualifier, update-DR pulse,
//   JCE1                 chain-1 enable
//   bus_req/we/addr/     request held until ack or timeout, with
//   wdata                direction, address and write data
//   bus_rdata, bus_ack   read data sampled with single-cycle ack
//   busy                 transaction outstanding
//   err                  sticky flags: [0] timeout, [1] overrun
module jtag_reg_ctrl #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              JTCK,
  input  logic              JRSTN,
  input  logic              JTDI,
  input  logic              JSHIFT,
  input  logic              JUPDATE,
  input  logic              JCE1,
  output logic              JTD1,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              busy,
  output logic [1:0]        err
);

  localparam int unsigned SR_W = 2 + ADDR_W + DATA_W;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_WRITE  = 2'b01,
    OP_READ   = 2'b10,
    OP_STATUS = 2'b11
  } op_t;

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q;
  logic [15:0]       cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        err_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  op_t               op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              start;
  logic              timeout_hit;
  logic              in_req;

  assign op       = op_t'(sr_q[SR_W-1 -: 2]);
  assign cmd_addr = sr_q[DATA_W +: ADDR_W];
  assign cmd_data = sr_q[DATA_W-1:0];
  assign in_req   = (state_q == REQ);

  always_comb begin
    state_d     = state_q;
    start       = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (JUPDATE && (op == OP_WRITE || op == OP_READ)) begin
          start   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // An ack in the final counted cycle takes priority over the timeout.
        if (bus_ack) begin
          state_d = IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d     = IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (JCE1 && JSHIFT)
        sr_q <= {JTDI, sr_q[SR_W-1:1]};
      else if (JCE1)
        sr_q <= {in_req, |err_q, addr_q, rdata_q};

      if (start) begin
        we_q    <= (op == OP_WRITE);
        addr_q  <= cmd_addr;
        wdata_q <= cmd_data;
        cnt_q   <= '0;
      end else if (in_req) begin
        cnt_q <= cnt_q + 16'd1;
      end

      if (in_req && bus_ack && !we_q)
        rdata_q <= bus_rdata;
      else if (timeout_hit)
        rdata_q <= '1;

      if (!in_req && JUPDATE && op == OP_STATUS) begin
        err_q <= '0;
      end else begin
        if (timeout_hit)
          err_q[0] <= 1'b1;
        if (in_req && JUPDATE)
          err_q[1] <= 1'b1;
      end
    end
  end

  assign JTD1      = sr_q[0];
  assign bus_req   = in_req;
  assign busy      = in_req;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign err       = err_q;

endmodule
